ad7606_cap_ctrl: RTL

AD7606_CAP_CTRL -- requirements
Module: ad7606_cap_ctrl

---
 rtl/ad7606_cap_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ad7606_cap_ctrl.sv
// AD7606 capture controller: paces conversion triggers, tracks packet
// completion, and flags overrun and packet timeout conditions.
module ad7606_cap_ctrl #(
  parameter int unsigned P_TIMEOUT    = 4096,
  parameter int unsigned P_MIN_PERIOD = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cfg_start,
  input  logic        i_cfg_stop,
  input  logic        i_cfg_single,
  input  logic [7:0]  i_cfg_chnl_num,
  input  logic [31:0] i_cfg_period,
  input  logic        i_ad_busy,
  input  logic        i_pkt_last,
  output logic        o_ad_start,
  output logic        o_cap_seek,
  output logic [7:0]  o_cap_chnnel_num,
  output logic        o_running,
  output logic        o_overrun,
  output logic        o_timeout,
  output logic [15:0] o_cap_cnt
);

  localparam int unsigned CH_W   = 8;
  localparam int unsigned PER_W  = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TO_W   = (P_TIMEOUT > 2) ? $clog2(P_TIMEOUT) : 1;
  localparam int unsigned CH_MAX = 8;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARM      = 2'd1,
    S_TRIG     = 2'd2,
    S_WAIT_PKT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PER_W-1:0]   period_lim_q, period_lim_d;
  logic [PER_W-1:0]   period_cnt_q, period_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               stop_pend_q, stop_pend_d;
  logic               single_q, single_d;
  logic               ad_start_q, ad_start_d;
  logic               cap_seek_q, cap_seek_d;
  logic [CH_W-1:0]    chnl_num_q, chnl_num_d;
  logic               running_q, running_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cap_cnt_q, cap_cnt_d;

  logic [PER_W-1:0]   cfg_lim_c;
  logic [CH_W-1:0]    cfg_chnl_c;
  logic               expired_c;
  logic               stop_eff_c;
  logic               to_hit_c;

  // Clamp requested channel count into the 1..8 range the ADC supports.
  always_comb begin
    cfg_chnl_c = i_cfg_chnl_num;
    if (i_cfg_chnl_num == CH_W'(0)) begin
      cfg_chnl_c = CH_W'(1);
    end else if (i_cfg_chnl_num > CH_W'(CH_MAX)) begin
      cfg_chnl_c = CH_W'(CH_MAX);
    end
  end

  // Saturation point of the period counter: max(period, minimum) - 1.
  always_comb begin
    if (i_cfg_period > PER_W'(P_MIN_PERIOD)) begin
      cfg_lim_c = i_cfg_period - PER_W'(1);
    end else begin
      cfg_lim_c = PER_W'(P_MIN_PERIOD) - PER_W'(1);
    end
  end

  // Status decodes shared by the next-state logic.
  always_comb begin
    expired_c  = (period_cnt_q >= period_lim_q);
    stop_eff_c = stop_pend_q | i_cfg_stop;
    to_hit_c   = (to_cnt_q == TO_W'(P_TIMEOUT - 1));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    period_lim_d = period_lim_q;
    period_cnt_d = expired_c ? period_lim_q : (period_cnt_q + PER_W'(1));
    to_cnt_d     = '0;
    stop_pend_d  = stop_pend_q;
    single_d     = single_q;
    ad_start_d   = 1'b0;
    cap_seek_d   = 1'b0;
    chnl_num_d   = chnl_num_q;
    overrun_d    = overrun_q;
    timeout_d    = 1'b0;
    cap_cnt_d    = cap_cnt_q;

    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (i_cfg_start && !i_cfg_stop) begin
          state_d      = S_ARM;
          single_d     = i_cfg_single;
          chnl_num_d   = cfg_chnl_c;
          period_lim_d = cfg_lim_c;
          // Start with the period already elapsed so the first trigger is immediate.
          period_cnt_d = cfg_lim_c;
          overrun_d    = 1'b0;
          cap_cnt_d    = '0;
        end
      end

      S_ARM: begin
        if (i_cfg_stop) begin
          state_d = S_IDLE;
        end else if (expired_c && !i_ad_busy) begin
          state_d      = S_TRIG;
          ad_start_d   = 1'b1;
          cap_seek_d   = 1'b1;
          period_cnt_d = '0;
        end
      end

      S_TRIG: begin
        state_d  = S_WAIT_PKT;
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (i_cfg_stop) begin
          stop_pend_d = 1'b1;
        end
      end

      S_WAIT_PKT: begin
        to_cnt_d    = to_cnt_q + TO_W'(1);
        stop_pend_d = stop_eff_c;
        if (expired_c) begin
          overrun_d = 1'b1;
        end
        if (i_pkt_last || to_hit_c) begin
          to_cnt_d = '0;
          state_d  = (single_q || stop_eff_c) ? S_IDLE : S_ARM;
          if (i_pkt_last) begin
            cap_cnt_d = cap_cnt_q + CNT_W'(1);
          end else begin
            timeout_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    running_d = (state_d != S_IDLE);
  end

  // State, counters and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      period_lim_q <= '0;
      period_cnt_q <= '0;
      to_cnt_q     <= '0;
      stop_pend_q  <= 1'b0;
      single_q     <= 1'b0;
      ad_start_q   <= 1'b0;
      cap_seek_q   <= 1'b0;
      chnl_num_q   <= '0;
      running_q    <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      cap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      period_lim_q <= period_lim_d;
      period_cnt_q <= period_cnt_d;
      to_cnt_q     <= to_cnt_d;
      stop_pend_q  <= stop_pend_d;
      single_q     <= single_d;
      ad_start_q   <= ad_start_d;
      cap_seek_q   <= cap_seek_d;
      chnl_num_q   <= chnl_num_d;
      running_q    <= running_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
      cap_cnt_q    <= cap_cnt_d;
    end
  end

  assign o_ad_start       = ad_start_q;
  assign o_cap_seek       = cap_seek_q;
  assign o_cap_chnnel_num = chnl_num_q;
  assign o_running        = running_q;
  assign o_overrun        = overrun_q;
  assign o_timeout        = timeout_q;
  assign o_cap_cnt        = cap_cnt_q;

endmodule
